// File: rtl/data_swap_stream.sv
// -----------------------------------------------------------------------------
// data_swap_stream
//
// Registered, streaming word-swap stage. Each WIDTH-bit word of a NUM_WORDS-word
// beat is reordered (none / half-word / byte / bit swap). The word order can
// optionally be reversed. Beats move over valid/ready through a 2-entry skid
// buffer, so out_data always comes from a register.
//
// Parameters
//   WIDTH      word width in bits (multiple of 16)
//   NUM_WORDS  words per beat; beat width BW = WIDTH*NUM_WORDS
//   CNT_W      width of the completed-transfer counter
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   cfg_swap_type  00 none, 01 half-word, 10 byte, 11 bit swap
//   cfg_word_rev   1: word k of the beat moves to position NUM_WORDS-1-k
//   cfg_we         config write strobe (taken only while idle)
//   cfg_busy       1 while any beat is held in the buffer
//   cfg_err        sticky: cfg_we seen while cfg_busy
//   in_valid/in_ready/in_data     input beat handshake, word 0 = [WIDTH-1:0]
//   out_valid/out_ready/out_data  output beat handshake
//   xfer_cnt       count of output handshakes, wraps
// -----------------------------------------------------------------------------
module data_swap_stream #(
   parameter int WIDTH     = 32,
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [1:0]                   cfg_swap_type,
   input  logic                         cfg_word_rev,
   input  logic                         cfg_we,
   output logic                         cfg_busy,
   output logic                         cfg_err,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH*NUM_WORDS-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH*NUM_WORDS-1:0]   out_data,
   output logic [CNT_W-1:0]             xfer_cnt
);

   localparam int BW = WIDTH * NUM_WORDS;

   typedef enum logic [1:0] {
      NO_SWAP        = 2'b00,
      HALF_WORD_SWAP = 2'b01,
      BYTE_SWAP      = 2'b10,
      BIT_SWAP       = 2'b11
   } swap_e;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } buf_state_e;

   // ---------------------------------------------------------------------------
   // Pure bit permutations
   // ---------------------------------------------------------------------------
   function automatic logic [WIDTH-1:0] swap_word(input logic [WIDTH-1:0] w,
                                                  input swap_e t);
      logic [WIDTH-1:0] r;
      r = w;
      case (t)
         HALF_WORD_SWAP: r = {w[WIDTH/2-1:0], w[WIDTH-1:WIDTH/2]};
         BYTE_SWAP: begin
            for (int b = 0; b < WIDTH/8; b++) begin
               r[b*8 +: 8] = w[(WIDTH/8-1-b)*8 +: 8];
            end
         end
         BIT_SWAP: begin
            for (int j = 0; j < WIDTH; j++) begin
               r[j] = w[WIDTH-1-j];
            end
         end
         default: r = w;
      endcase
      return r;
   endfunction

   // Word reversal is applied after the per-word swap.
   function automatic logic [BW-1:0] transform(input logic [BW-1:0] d,
                                               input swap_e t,
                                               input logic rev);
      logic [BW-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (rev) begin
            r[k*WIDTH +: WIDTH] = swap_word(d[(NUM_WORDS-1-k)*WIDTH +: WIDTH], t);
         end else begin
            r[k*WIDTH +: WIDTH] = swap_word(d[k*WIDTH +: WIDTH], t);
         end
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   buf_state_e       state_q, state_d;
   logic [BW-1:0]    main_q, main_d;
   logic [BW-1:0]    skid_q, skid_d;
   logic             valid_q;
   logic             in_ready_q;
   swap_e            cfg_swap_q;
   logic             cfg_rev_q;
   logic             cfg_err_q;
   logic [CNT_W-1:0] xfer_cnt_q;

   logic          accept;
   logic          out_hs;
   logic [BW-1:0] xf_data;

   assign accept  = in_valid & in_ready_q;
   assign out_hs  = valid_q & out_ready;
   // The beat is transformed with the config registers as they stand in the
   // acceptance cycle; a same-cycle cfg_we only takes effect on the next beat.
   assign xf_data = transform(in_data, cfg_swap_q, cfg_rev_q);

   // ---------------------------------------------------------------------------
   // Buffer next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = xf_data;
               state_d = ONE;
            end
         end
         ONE: begin
            case ({accept, out_hs})
               2'b11: main_d = xf_data;
               2'b10: begin
                  skid_d  = xf_data;
                  state_d = TWO;
               end
               2'b01: state_d = EMPTY;
               default: ;
            endcase
         end
         TWO: begin
            // in_ready is low here, so no accept can coincide.
            if (out_hs) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers. Flags are registered from the next state, so in_ready has no
   // combinational path from out_ready.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         // NOTE: the data registers are reset too, because out_data must read
         // zero after reset.
         main_q     <= '0;
         skid_q     <= '0;
         valid_q    <= 1'b0;
         in_ready_q <= 1'b1;
         cfg_swap_q <= NO_SWAP;
         cfg_rev_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates in step at the edge.
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         valid_q    <= (state_d != EMPTY);
         in_ready_q <= (state_d != TWO);
         if (cfg_we) begin
            if (valid_q) begin
               cfg_err_q <= 1'b1;
            end else begin
               cfg_swap_q <= swap_e'(cfg_swap_type);
               cfg_rev_q  <= cfg_word_rev;
            end
         end
         if (out_hs) begin
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_valid = valid_q;
   assign cfg_busy  = valid_q;
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;
   assign cfg_err   = cfg_err_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_data_swap_stream.sv
module tb_data_swap_stream;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int BW = W * N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    cfg_swap_type;
   logic          cfg_word_rev;
   logic          cfg_we;
   logic          cfg_busy;
   logic          cfg_err;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic [15:0]   xfer_cnt;

   // Second instance with a narrow counter for the wrap check.
   logic          c_cfg_busy, c_cfg_err, c_in_valid, c_in_ready;
   logic          c_out_valid, c_out_ready;
   logic [BW-1:0] c_in_data, c_out_data;
   logic [3:0]    c_xfer_cnt;
   logic [1:0]    c_swap;
   logic          c_rev, c_we;

   always #5 clk = ~clk;

   data_swap_stream #(.WIDTH(W), .NUM_WORDS(N), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_swap_type(cfg_swap_type), .cfg_word_rev(cfg_word_rev), .cfg_we(cfg_we),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .xfer_cnt(xfer_cnt)
   );

   data_swap_stream #(.WIDTH(W), .NUM_WORDS(N), .CNT_W(4)) u_dut_cnt4 (
      .clk(clk), .rst_n(rst_n),
      .cfg_swap_type(c_swap), .cfg_word_rev(c_rev), .cfg_we(c_we),
      .cfg_busy(c_cfg_busy), .cfg_err(c_cfg_err),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .xfer_cnt(c_xfer_cnt)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_hs    = 0;
   int            n_hs2   = 0;
   logic          last_acc;
   logic [BW-1:0] sb[$];
   logic [1:0]    m_swap;
   logic          m_rev;
   logic [31:0]   mode_exp[4];

   // Reference model written bit by bit from the permutation definitions.
   function automatic logic [W-1:0] ref_word(input logic [W-1:0] w, input logic [1:0] t);
      logic [W-1:0] r;
      for (int j = 0; j < W; j++) begin
         case (t)
            2'd0: r[j] = w[j];
            2'd1: r[j] = w[(j + W/2) % W];
            2'd2: r[j] = w[(W/8 - 1 - j/8)*8 + (j % 8)];
            default: r[j] = w[W-1-j];
         endcase
      end
      return r;
   endfunction

   function automatic logic [BW-1:0] ref_beat(input logic [BW-1:0] d, input logic [1:0] t,
                                              input logic rev);
      logic [BW-1:0] r;
      int src;
      for (int k = 0; k < N; k++) begin
         src = rev ? (N-1-k) : k;
         r[k*W +: W] = ref_word(d[src*W +: W], t);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Handshakes are judged on the stable pre-edge values;
   // outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      logic          acc, hs;
      logic [BW-1:0] exp;
      acc = in_valid & in_ready;
      hs  = out_valid & out_ready;
      if (hs) begin
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_underflow: observed output %0h expected none", out_data);
         end
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("sb_data", out_data, exp);
         end
         n_hs++;
      end
      if (acc) sb.push_back(ref_beat(in_data, m_swap, m_rev));
      if (cfg_we && !cfg_busy) begin
         m_swap = cfg_swap_type;
         m_rev  = cfg_word_rev;
      end
      if (c_out_valid && c_out_ready) n_hs2++;
      @(posedge clk);
      #1;
      last_acc = acc;
   endtask

   task automatic push_beat(input logic [BW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (last_acc) break;
      end
      in_valid = 1'b0;
      check("accept_timeout", last_acc, 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid && sb.size() == 0) break;
         tick();
      end
      check("drain_valid", out_valid, 0);
      check("drain_sb_left", sb.size(), 0);
   endtask

   task automatic cfg_write(input logic [1:0] t, input logic rev);
      cfg_we        = 1'b1;
      cfg_swap_type = t;
      cfg_word_rev  = rev;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      m_swap = 2'd0;
      m_rev  = 1'b0;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mode_exp = '{32'h1234_5678, 32'h5678_1234, 32'h7856_3412, 32'h1E6A_2C48};
      rst_n = 1'b0;
      cfg_swap_type = 2'd0; cfg_word_rev = 1'b0; cfg_we = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      c_swap = 2'd0; c_rev = 1'b0; c_we = 1'b0;
      c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
      m_swap = 2'd0; m_rev = 1'b0; last_acc = 1'b0;

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_busy", cfg_busy, 0);
      check("rst_err", cfg_err, 0);
      check("rst_xfer", xfer_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Swap modes on word 0
      for (int t = 0; t < 4; t++) begin
         cfg_write(2'(t), 1'b0);
         out_ready = 1'b0;
         push_beat({32'hDEAD_BEEF, 32'h0F1E_2D3C, 32'hA5A5_0001, 32'h1234_5678});
         check($sformatf("mode%0d_word0", t), out_data[31:0], mode_exp[t]);
         drain();
      end

      // Word reversal
      cfg_write(2'd0, 1'b1);
      out_ready = 1'b0;
      push_beat({32'hA, 32'hB, 32'hC, 32'hD});
      check("word_rev", out_data, {32'hD, 32'hC, 32'hB, 32'hA});
      drain();
      cfg_write(2'd0, 1'b0);

      // Config race: same-cycle beat uses old config
      out_ready     = 1'b0;
      cfg_we        = 1'b1;
      cfg_swap_type = 2'd2;
      cfg_word_rev  = 1'b0;
      in_valid      = 1'b1;
      in_data       = {96'h0, 32'h1234_5678};
      tick();
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      check("race_old_cfg", out_data[31:0], 32'h1234_5678);
      out_ready = 1'b1;
      push_beat({96'h1, 32'h1234_5678});
      check("race_new_cfg", out_data[31:0], 32'h7856_3412);
      out_ready = 1'b0;
      cfg_write(2'd1, 1'b0);
      check("busy_write_err", cfg_err, 1);
      check("busy_write_hold", out_data[31:0], 32'h7856_3412);
      drain();
      out_ready = 1'b0;
      push_beat({96'h2, 32'h1234_5678});
      check("cfg_unchanged", out_data[31:0], 32'h7856_3412);
      drain();

      // Backpressure
      n_hs      = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {32'h0B0B_0000, 32'h1, 32'h2, 32'h3};
      tick();
      check("bp_acc0", last_acc, 1);
      in_data = {32'h0B0B_0001, 32'h4, 32'h5, 32'h6};
      tick();
      check("bp_acc1", last_acc, 1);
      check("bp_in_ready_low", in_ready, 0);
      in_data = {32'h0B0B_0002, 32'h7, 32'h8, 32'h9};
      tick();
      check("bp_no_acc", last_acc, 0);
      check("bp_stable", out_data, ref_beat({32'h0B0B_0000, 32'h1, 32'h2, 32'h3}, 2'd2, 1'b0));
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (last_acc) break;
      end
      in_valid = 1'b0;
      check("bp_acc2", last_acc, 1);
      drain();
      check("bp_count", n_hs, 3);

      // Reset mid-stream with two beats buffered
      cfg_write(2'd3, 1'b0);
      out_ready = 1'b0;
      push_beat({32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888});
      push_beat({32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE, 32'hFFFF_0000});
      check("pre_rst_busy", cfg_busy, 1);
      check("pre_rst_in_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", cfg_busy, 0);
      check("mid_rst_xfer", xfer_cnt, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_err", cfg_err, 0);
      sb.delete();
      m_swap = 2'd0;
      m_rev  = 1'b0;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", in_ready, 1);
      push_beat({32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_F0F0, 32'h1234_5678});
      check("post_rst_unmod", out_data, {32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_F0F0, 32'h1234_5678});
      drain();

      // Throughput
      do_reset();
      n_hs      = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = {$urandom(), $urandom(), $urandom(), 32'(i)};
         tick();
         check("tp_accept", last_acc, 1);
      end
      in_valid = 1'b0;
      tick();
      check("tp_hs", n_hs, 100);
      check("tp_xfer", xfer_cnt, 100);
      check("tp_valid", out_valid, 0);

      // Counter wrap on the 4-bit instance
      n_hs2       = 0;
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      for (int i = 0; i < 17; i++) begin
         c_in_data = BW'(i);
         tick();
         if (i == 16) check("wrap_at16", c_xfer_cnt, 0);
      end
      c_in_valid = 1'b0;
      tick();
      check("wrap_hs", n_hs2, 17);
      check("wrap_xfer", c_xfer_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
